// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Multi-cycle data SRAM placed in the CPU MEM stage. Accepts one
//            load/store at a time, waits LATENCY cycles, then pulses ack_o
//            with read data (load) or commits the write (store). stall_o
//            freezes the pipeline while a transaction is outstanding.
// Ports    : clk_i    - clock
//            rst_i    - synchronous active-low reset
//            req_i    - request; addr/we/wdata are captured when accepted
//            we_i     - 1 = store, 0 = load
//            addr_i   - byte address (word index = addr_i[AW+1:2])
//            wdata_i  - store data
//            stall_o  - pipeline freeze
//            ack_o    - one-cycle completion pulse
//            rdata_o  - load data, valid in the ack cycle, held until next ack
//            err_o    - with ack_o: misaligned or out-of-range address
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3      // legal range 1..15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int          c_AW       = $clog2(DEPTH);
  // 33 bits so the range check cannot overflow for large DEPTH.
  localparam logic [32:0] c_LIMIT    = 33'(4 * DEPTH);
  localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0]  c_IDLE = 2'd0;
  localparam logic [1:0]  c_WAIT = 2'd1;
  localparam logic [1:0]  c_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [3:0]      r_cnt;

  // Transaction captured at accept; inputs are ignored afterwards.
  logic            r_we;
  logic            r_err;
  logic [c_AW-1:0] r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;

  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_in_err;
  logic [c_AW-1:0] w_in_idx;
  logic            w_enter_done;
  logic            w_rd_err;
  logic            w_rd_we;
  logic [c_AW-1:0] w_rd_idx;

  assign w_accept = (r_state == c_IDLE) && req_i;
  assign w_in_err = (addr_i[1:0] != 2'b00) || ({1'b0, addr_i} >= c_LIMIT);
  assign w_in_idx = addr_i[c_AW+1:2];

  // With LATENCY==1 the DONE state is entered at the accept edge itself, so
  // the read must use the live inputs rather than the not-yet-captured copy.
  assign w_enter_done = ((r_state == c_WAIT) && (r_cnt == 4'd1)) ||
                        (w_accept && (LATENCY == 1));
  assign w_rd_err = (r_state == c_IDLE) ? w_in_err : r_err;
  assign w_rd_we  = (r_state == c_IDLE) ? we_i     : r_we;
  assign w_rd_idx = (r_state == c_IDLE) ? w_in_idx : r_idx;

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (req_i) begin
          w_next = (LATENCY == 1) ? c_DONE : c_WAIT;
        end
      end
      c_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next = c_DONE;
        end
      end
      c_DONE:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    stall_o = 1'b0;
    ack_o   = 1'b0;
    err_o   = 1'b0;
    case (r_state)
      c_IDLE: stall_o = req_i;
      c_WAIT: stall_o = 1'b1;
      c_DONE: begin
        ack_o = 1'b1;
        err_o = r_err;
      end
      default: ;
    endcase
  end

  assign rdata_o = r_rdata;

  // ---------------------------------------------------------------- latency counter
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= c_CNT_INIT;
    end else if (r_state == c_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // ---------------------------------------------------------------- request capture
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_we    <= we_i;
      r_err   <= w_in_err;
      r_idx   <= w_in_idx;
      r_wdata <= wdata_i;
    end
  end

  // ---------------------------------------------------------------- read data
  // Errors force zero; good stores leave the previous load data in place.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rdata <= 32'd0;
    end else if (w_enter_done) begin
      if (w_rd_err) begin
        r_rdata <= 32'd0;
      end else if (!w_rd_we) begin
        r_rdata <= r_mem[w_rd_idx];
      end
    end
  end

  // ---------------------------------------------------------------- storage
  // Write commits on the edge leaving DONE; a reset on that edge discards it.
  always_ff @(posedge clk_i) begin
    if (rst_i && (r_state == c_DONE) && r_we && !r_err) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule
`default_nettype wire
